// File: rtl/mbus_arbiter.sv
// Two-master round-robin arbiter for the shared Wishbone-classic memory bus.
// One owner per transfer. A hung transfer is ended with a one-cycle error pulse
// after TIMEOUT_CYCLES busy cycles without ack. Every transfer returns through
// IDLE, so the bus is released for at least one cycle between owners.
module mbus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AW             = 32,
  parameter int DW             = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // master 0 (BIU memory port)
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // master 1 (DMA / video fetch)
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // bus switch side
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  output logic [3:0]    sel_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  output logic [1:0]    grant_o
);

  // Counter is wide enough to hold TIMEOUT_CYCLES-1; a disabled timeout keeps a
  // 1-bit counter that simply saturates.
  localparam int CW        = (TIMEOUT_CYCLES <= 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_LAST_I = (TIMEOUT_CYCLES <= 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // index of the granted master
  logic          last_q,  last_d;    // master that owned the previous transfer
  logic [CW-1:0] count_q, count_d;   // busy cycles spent waiting for ack

  // Master inputs gathered into arrays so the owner can index them directly.
  logic [1:0]    m_stb;
  logic [1:0]    m_we;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_wdat [2];
  logic [3:0]    m_sel [2];
  logic [1:0]    ack_vec;
  logic [1:0]    err_vec;
  logic [DW-1:0] rd_dat [2];
  logic          owner_stb;
  logic          to_hit;

  assign m_stb     = {m1_stb_i, m0_stb_i};
  assign m_we      = {m1_we_i, m0_we_i};
  assign m_adr[0]  = m0_adr_i;
  assign m_adr[1]  = m1_adr_i;
  assign m_wdat[0] = m0_dat_i;
  assign m_wdat[1] = m1_dat_i;
  assign m_sel[0]  = m0_sel_i;
  assign m_sel[1]  = m1_sel_i;

  assign owner_stb = m_stb[owner_q];
  assign to_hit    = TO_EN && (count_q == TO_LAST);

  // State register: reset parks the arbiter idle with master 0 winning the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Arbitration, transfer termination and slave-side muxing.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    adr_o   = '0;
    dat_o   = '0;
    sel_o   = '0;
    ack_vec = 2'b00;
    err_vec = 2'b00;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (|m_stb) begin
          state_d = BUSY;
          // On a tie the master that did not own the last transfer wins.
          owner_d = (&m_stb) ? ~last_q : m_stb[1];
        end
      end
      BUSY: begin
        stb_o = owner_stb;
        we_o  = m_we[owner_q];
        adr_o = m_adr[owner_q];
        dat_o = m_wdat[owner_q];
        sel_o = m_sel[owner_q];
        if (ack_i) begin
          ack_vec[owner_q] = 1'b1;
          last_d  = owner_q;
          count_d = '0;
          state_d = IDLE;
        end else if (!owner_stb) begin
          // Owner abandoned the transfer: release without ack.
          last_d  = owner_q;
          count_d = '0;
          state_d = IDLE;
        end else if (to_hit) begin
          // Hung transfer: withdraw the strobe and report an error instead.
          err_vec[owner_q] = 1'b1;
          stb_o   = 1'b0;
          last_d  = owner_q;
          count_d = '0;
          state_d = IDLE;
        end else if (count_q != CNT_MAX) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset cuts the bus immediately; the interrupted transfer sees no response.
    if (rst_i) begin
      stb_o   = 1'b0;
      we_o    = 1'b0;
      adr_o   = '0;
      dat_o   = '0;
      sel_o   = '0;
      ack_vec = 2'b00;
      err_vec = 2'b00;
    end
  end

  // Read data is routed only to the current owner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rd_dat[gi] = (state_q == BUSY && !rst_i && owner_q == gi[0]) ? dat_i : '0;
  end

  assign m0_dat_o = rd_dat[0];
  assign m1_dat_o = rd_dat[1];
  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];
  assign m0_err_o = err_vec[0];
  assign m1_err_o = err_vec[1];
  assign grant_o  = (state_q == BUSY) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_mbus_arbiter.sv
// Bench for mbus_arbiter: directed scenarios with literal expectations followed
// by randomized traffic, all checked every cycle against a transaction-level model.
module tb_mbus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_stb [2];
  logic        t_we  [2];
  logic [31:0] t_adr [2];
  logic [31:0] t_wd  [2];
  logic [3:0]  t_sel [2];
  logic [31:0] s_dat = '0;
  logic        s_ack = 1'b0;

  logic [31:0] m0_dat_o, m1_dat_o, adr_o, dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  // Model state: owner (-1 = bus free), previous owner, busy cycles waited.
  int mo_own  = -1;
  int mo_last = 1;
  int mo_wait = 0;
  logic [1:0] prev_ack = 2'b00;
  logic [1:0] prev_err = 2'b00;

  mbus_arbiter #(.TIMEOUT_CYCLES(TO), .AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_stb_i(t_stb[0]), .m0_we_i(t_we[0]), .m0_adr_i(t_adr[0]), .m0_dat_i(t_wd[0]),
    .m0_sel_i(t_sel[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(t_stb[1]), .m1_we_i(t_we[1]), .m1_adr_i(t_adr[1]), .m1_dat_i(t_wd[1]),
    .m1_sel_i(t_sel[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .dat_i(s_dat), .ack_i(s_ack), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model.
  logic [1:0]  e_ack, e_err, e_gnt;
  logic        e_stb, e_we, g_stb, fire;
  logic [31:0] e_adr, e_wd, e_rd0, e_rd1;
  logic [3:0]  e_sel;
  always @(negedge clk) begin
    e_ack = 2'b00; e_err = 2'b00; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_wd = '0; e_sel = '0; e_rd0 = '0; e_rd1 = '0;
    g_stb = 1'b0; fire = 1'b0;
    e_gnt = (mo_own < 0) ? 2'b00 : 2'(1 << mo_own);
    if (!rst && mo_own >= 0) begin
      g_stb = t_stb[mo_own];
      fire  = (mo_wait == TO - 1) && !s_ack && g_stb;
      e_stb = g_stb && !fire;
      e_we  = t_we[mo_own];
      e_adr = t_adr[mo_own];
      e_wd  = t_wd[mo_own];
      e_sel = t_sel[mo_own];
      e_ack[mo_own] = s_ack;
      e_err[mo_own] = fire;
      if (mo_own == 0) e_rd0 = s_dat; else e_rd1 = s_dat;
    end
    chk("grant_o", grant_o, e_gnt);
    chk("stb_o", stb_o, e_stb);
    chk("we_o", we_o, e_we);
    chk("adr_o", adr_o, e_adr);
    chk("dat_o", dat_o, e_wd);
    chk("sel_o", sel_o, e_sel);
    chk("m0_ack_o", m0_ack_o, e_ack[0]);
    chk("m1_ack_o", m1_ack_o, e_ack[1]);
    chk("m0_err_o", m0_err_o, e_err[0]);
    chk("m1_err_o", m1_err_o, e_err[1]);
    chk("m0_dat_o", m0_dat_o, e_rd0);
    chk("m1_dat_o", m1_dat_o, e_rd1);
    prev_ack = e_ack;
    prev_err = e_err;
    if (rst) begin
      mo_own = -1; mo_last = 1; mo_wait = 0;
    end else if (mo_own < 0) begin
      if (t_stb[0] || t_stb[1]) begin
        mo_own  = (t_stb[0] && t_stb[1]) ? 1 - mo_last : (t_stb[1] ? 1 : 0);
        mo_wait = 0;
      end
    end else if (s_ack || !g_stb || fire) begin
      mo_last = mo_own;
      mo_own  = -1;
    end else begin
      mo_wait++;
    end
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      t_stb[n] = 1'b0; t_we[n] = 1'b0; t_adr[n] = '0; t_wd[n] = '0; t_sel[n] = '0;
    end
    repeat (2) step();
    chk("reset_stb", stb_o, 1'b0);
    chk("reset_grant", grant_o, 2'b00);
    rst = 1'b0;

    // Read by m0, ack two cycles after the strobe appears.
    step();
    t_stb[0] = 1'b1; t_we[0] = 1'b0; t_adr[0] = 32'h0000_0100; t_sel[0] = 4'hF;
    #1 chk("t1_idle_stb", stb_o, 1'b0);
    step();
    #1 chk("t1_stb", stb_o, 1'b1);
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_adr", adr_o, 32'h0000_0100);
    step();
    step();
    s_ack = 1'b1; s_dat = 32'hCAFEF00D;
    #1 chk("t1_ack", m0_ack_o, 1'b1);
    chk("t1_rdata", m0_dat_o, 32'hCAFEF00D);
    chk("t1_m1_ack", m1_ack_o, 1'b0);
    chk("t1_m1_dat", m1_dat_o, 32'h0);
    step();
    s_ack = 1'b0; t_stb[0] = 1'b0;
    #1 chk("t1_gap_stb", stb_o, 1'b0);
    chk("t1_gap_grant", grant_o, 2'b00);

    // Simultaneous requests after reset alternate 0,1,0,1.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    t_stb[0] = 1'b1; t_stb[1] = 1'b1; t_adr[1] = 32'h0000_0200; t_sel[1] = 4'h3;
    for (int k = 1; k <= 7; k++) begin
      step();
      s_ack = (k % 2 == 1);
      if (k % 2 == 1) begin
        #1 chk("t2_grant", grant_o, (k % 4 == 1) ? 2'b01 : 2'b10);
        chk("t2_m0_ack", m0_ack_o, (k % 4 == 1));
        chk("t2_m1_ack", m1_ack_o, (k % 4 == 3));
      end
    end
    step(); s_ack = 1'b0; t_stb[0] = 1'b0; t_stb[1] = 1'b0;

    // m1 write never acked: error in the 8th busy cycle, then pending m0 served.
    step();
    t_stb[1] = 1'b1; t_we[1] = 1'b1; t_wd[1] = 32'h1234_5678;
    for (int b = 1; b <= 9; b++) begin
      step();
      if (b == 2) t_stb[0] = 1'b1;
      if (b == 9) t_stb[1] = 1'b0;
      if (b == 7) begin
        #1 chk("t3_pre_err", m1_err_o, 1'b0);
        chk("t3_pre_stb", stb_o, 1'b1);
      end
      if (b == 8) begin
        #1 chk("t3_err", m1_err_o, 1'b1);
        chk("t3_err_stb", stb_o, 1'b0);
        chk("t3_err_ack", m1_ack_o, 1'b0);
      end
      if (b == 9) begin
        #1 chk("t3_idle_grant", grant_o, 2'b00);
      end
    end
    step(); s_ack = 1'b1;
    #1 chk("t3_next_grant", grant_o, 2'b01);
    chk("t3_next_ack", m0_ack_o, 1'b1);
    step(); s_ack = 1'b0; t_stb[0] = 1'b0;

    // Ack in the same cycle the timeout would fire.
    step(); t_stb[0] = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      step();
      s_ack = (b == 8);
      if (b == 8) begin
        #1 chk("t4_ack", m0_ack_o, 1'b1);
        chk("t4_err", m0_err_o, 1'b0);
        chk("t4_stb", stb_o, 1'b1);
      end
    end
    step(); s_ack = 1'b0; t_stb[0] = 1'b0;

    // m0 aborts after two busy cycles; waiting m1 is granted next.
    step(); t_stb[0] = 1'b1;
    step(); t_stb[1] = 1'b1;
    step();
    step(); t_stb[0] = 1'b0;
    #1 chk("t5_abort_stb", stb_o, 1'b0);
    chk("t5_abort_ack", m0_ack_o, 1'b0);
    step();
    #1 chk("t5_idle_grant", grant_o, 2'b00);
    step(); s_ack = 1'b1;
    #1 chk("t5_m1_grant", grant_o, 2'b10);
    chk("t5_m1_ack", m1_ack_o, 1'b1);
    step(); s_ack = 1'b0; t_stb[1] = 1'b0;

    // Reset in the middle of an m1 transfer.
    step(); t_stb[1] = 1'b1;
    step();
    #1 chk("t6_busy_grant", grant_o, 2'b10);
    step(); rst = 1'b1; s_ack = 1'b1; t_stb[0] = 1'b1;
    #1 chk("t6_rst_stb", stb_o, 1'b0);
    chk("t6_rst_ack", m1_ack_o, 1'b0);
    step(); rst = 1'b0; s_ack = 1'b0;
    #1 chk("t6_post_grant", grant_o, 2'b00);
    chk("t6_post_stb", stb_o, 1'b0);
    step(); s_ack = 1'b1;
    #1 chk("t6_first_grant", grant_o, 2'b01);
    chk("t6_first_ack", m0_ack_o, 1'b1);
    step(); s_ack = 1'b0; t_stb[0] = 1'b0; t_stb[1] = 1'b0;

    // Randomized traffic: masters hold requests until ack/err, occasionally abort.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 2; n++) begin
        if (t_stb[n]) begin
          if (prev_ack[n] || prev_err[n] || $urandom_range(0, 24) == 0) t_stb[n] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          t_stb[n] = 1'b1;
          t_we[n]  = 1'($urandom);
          t_adr[n] = $urandom;
          t_wd[n]  = $urandom;
          t_sel[n] = 4'($urandom);
        end
      end
      if (c < 1000)      s_ack = ($urandom_range(0, 2) == 0);
      else if (c < 1600) s_ack = 1'b0;
      else               s_ack = ($urandom_range(0, 5) == 0);
      s_dat = $urandom;
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
